// File: rtl/complex_acc_pkg.sv
// Shared types and defaults for the complex accumulator slice.
package complex_acc_pkg;

    localparam int PW_DEF = 64;
    localparam int AW_DEF = 80;
    localparam int LW_DEF = 16;

    // Widest accumulator the sign-extension helper can produce.
    localparam int SEXT_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Replicate bit msb of v into every higher bit position.
    function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v,
                                               input logic [6:0]        msb);
        logic [SEXT_W-1:0] r;
        r = '0;
        for (int i = 0; i < SEXT_W; i++) begin
            r[i] = (i <= int'(msb)) ? v[i] : v[msb];
        end
        return r;
    endfunction

endpackage

// File: rtl/cplx_acc_lane.sv
// One accumulator lane: AW-bit wrapping signed sum with a sticky overflow flag.
module cplx_acc_lane
    import complex_acc_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          add,
    input  logic [PW-1:0] prod,
    output logic [AW-1:0] acc,
    output logic          ovf
);

    logic [AW-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] ext;
    logic [AW-1:0] sum;
    logic          ovf_add;

    // Sign-extend the product, add it, and flag a same-sign add whose result flips sign.
    always_comb begin
        ext     = AW'(sext(SEXT_W'(prod), 7'(PW - 1)));
        sum     = acc_q + ext;
        ovf_add = (acc_q[AW-1] == ext[AW-1]) && (sum[AW-1] != acc_q[AW-1]);
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (add) begin
            acc_d = sum;
            ovf_d = ovf_q | ovf_add;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/complex_accumulator.sv
// Accumulates a programmed number of complex products into wide real/imag sums.
//
// Handshake: a product transfers on a rising edge where in_valid && in_ready;
// in_ready depends only on state (high in ACCUM). A result transfers on a
// rising edge where out_valid && out_ready; out_valid is high only in DONE and
// acc/ovf are held stable for the whole time out_valid is high.
module complex_accumulator
    import complex_acc_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int AW = AW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] len,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] pr,
    input  logic [PW-1:0] pi,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] acc_r,
    output logic [AW-1:0] acc_i,
    output logic          ovf_r,
    output logic          ovf_i,
    output logic          busy,
    output state_e        dbg_state
);

    state_e        state_q, state_d;
    logic [LW-1:0] count_q, count_d;
    logic          lane_clr;
    logic          lane_add;

    // Next-state, remaining-count and lane-enable logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        lane_clr = 1'b0;
        lane_add = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lane_clr = 1'b1;
                    count_d  = len;
                    state_d  = (len == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_valid) begin
                    lane_add = 1'b1;
                    count_d  = count_q - LW'(1);
                    if (count_q == LW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    cplx_acc_lane #(.PW(PW), .AW(AW)) u_lane_r (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (lane_clr),
        .add   (lane_add),
        .prod  (pr),
        .acc   (acc_r),
        .ovf   (ovf_r)
    );

    cplx_acc_lane #(.PW(PW), .AW(AW)) u_lane_i (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (lane_clr),
        .add   (lane_add),
        .prod  (pi),
        .acc   (acc_i),
        .ovf   (ovf_i)
    );

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_complex_accumulator.sv
// Bench for complex_accumulator: an 80-bit and a 64-bit instance share stimulus.
module tb_complex_accumulator;
  import complex_acc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] pr = '0;
  logic [63:0] pi = '0;

  logic        in_ready_a, out_valid_a, ovf_r_a, ovf_i_a, busy_a;
  logic [79:0] acc_r_a, acc_i_a;
  state_e      dbg_a;
  logic        in_ready_b, out_valid_b, ovf_r_b, ovf_i_b, busy_b;
  logic [63:0] acc_r_b, acc_i_b;
  state_e      dbg_b;

  complex_accumulator u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_a), .pr(pr), .pi(pi),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .acc_r(acc_r_a), .acc_i(acc_i_a), .ovf_r(ovf_r_a), .ovf_i(ovf_i_a),
    .busy(busy_a), .dbg_state(dbg_a)
  );

  complex_accumulator #(.PW(64), .AW(64), .LW(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_b), .pr(pr), .pi(pi),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .acc_r(acc_r_b), .acc_i(acc_i_b), .ovf_r(ovf_r_b), .ovf_i(ovf_i_b),
    .busy(busy_b), .dbg_state(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fails = 0;
  logic [63:0] q_r[$];
  logic [63:0] q_i[$];

  // Reference sums: exact integer addition, wrapped to the lane width;
  // overflow means the exact value is not representable after the wrap.
  logic [79:0] m_r80, m_i80;
  logic [63:0] m_r64, m_i64;
  bit          o_r80, o_i80, o_r64, o_i64;

  task automatic madd80(inout logic [79:0] a, inout bit o, input logic [63:0] p);
    logic signed [129:0] ex;
    ex = 130'($signed(a)) + 130'($signed(p));
    a = ex[79:0];
    if (130'($signed(a)) != ex) o = 1'b1;
  endtask

  task automatic madd64(inout logic [63:0] a, inout bit o, input logic [63:0] p);
    logic signed [129:0] ex;
    ex = 130'($signed(a)) + 130'($signed(p));
    a = ex[63:0];
    if (130'($signed(a)) != ex) o = 1'b1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sums(input string tag);
    check({tag, "_acc_r80"}, 128'(acc_r_a), 128'(m_r80));
    check({tag, "_acc_i80"}, 128'(acc_i_a), 128'(m_i80));
    check({tag, "_acc_r64"}, 128'(acc_r_b), 128'(m_r64));
    check({tag, "_acc_i64"}, 128'(acc_i_b), 128'(m_i64));
    check({tag, "_ovf_r80"}, 128'(ovf_r_a), 128'(o_r80));
    check({tag, "_ovf_i80"}, 128'(ovf_i_a), 128'(o_i80));
    check({tag, "_ovf_r64"}, 128'(ovf_r_b), 128'(o_r64));
    check({tag, "_ovf_i64"}, 128'(ovf_i_b), 128'(o_i64));
  endtask

  task automatic check_done(input string tag);
    check({tag, "_out_valid"}, 128'({out_valid_a, out_valid_b}), 128'(2'b11));
    check({tag, "_in_ready"}, 128'({in_ready_a, in_ready_b}), 128'(2'b00));
    check({tag, "_busy"}, 128'({busy_a, busy_b}), 128'(2'b11));
    check_sums(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_flags"}, 128'({in_ready_a, out_valid_a, busy_a, ovf_r_a, ovf_i_a,
                                 in_ready_b, out_valid_b, busy_b, ovf_r_b, ovf_i_b}), 128'(0));
    check({tag, "_acc80"}, 128'({acc_r_a, acc_i_a}), 128'(0));
    check({tag, "_acc64"}, 128'({acc_r_b, acc_i_b}), 128'(0));
  endtask

  // Runs one job using the products queued in q_r/q_i.
  task automatic run_job(input string tag, input int min_gap, input int max_gap,
                         input int hold, input bit start_at_handoff);
    int n;
    n = q_r.size();
    m_r80 = '0; m_i80 = '0; m_r64 = '0; m_i64 = '0;
    o_r80 = 0; o_i80 = 0; o_r64 = 0; o_i64 = 0;
    start = 1'b1;
    len = 16'(n);
    step();
    start = 1'b0;
    check({tag, "_start_busy"}, 128'({busy_a, busy_b}), 128'(2'b11));
    check({tag, "_start_ready"}, 128'(in_ready_a), 128'(n != 0));
    check({tag, "_start_valid"}, 128'(out_valid_a), 128'(n == 0));
    check_sums({tag, "_start"});
    for (int i = 0; i < n; i++) begin
      int g;
      g = $urandom_range(max_gap, min_gap);
      in_valid = 1'b0;
      for (int k = 0; k < g; k++) begin
        pr = {$urandom, $urandom};
        pi = {$urandom, $urandom};
        step();
        check({tag, "_gap_ready"}, 128'({in_ready_a, in_ready_b, out_valid_a}), 128'(3'b110));
        check_sums({tag, "_gap"});
      end
      check({tag, "_xfer_ready"}, 128'({in_ready_a, in_ready_b}), 128'(2'b11));
      in_valid = 1'b1;
      pr = q_r[i];
      pi = q_i[i];
      madd80(m_r80, o_r80, q_r[i]);
      madd80(m_i80, o_i80, q_i[i]);
      madd64(m_r64, o_r64, q_r[i]);
      madd64(m_i64, o_i64, q_i[i]);
      step();
    end
    in_valid = 1'b0;
    check_done({tag, "_done"});
    // Results must stay frozen while the consumer stalls, whatever the inputs do.
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      start = 1'($urandom_range(1, 0));
      len = 16'($urandom_range(5, 0));
      in_valid = 1'($urandom_range(1, 0));
      pr = {$urandom, $urandom};
      pi = {$urandom, $urandom};
      step();
      check_done({tag, "_hold"});
    end
    start = start_at_handoff;
    len = 16'd3;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    start = 1'b0;
    check({tag, "_idle_flags"}, 128'({busy_a, busy_b, out_valid_a, in_ready_a}), 128'(0));
    check_sums({tag, "_idle_hold"});
    if (start_at_handoff) begin
      step();
      check({tag, "_handoff_start_ignored"}, 128'({busy_a, busy_b}), 128'(0));
    end
    q_r.delete();
    q_i.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    #12;
    check_reset_values("reset");
    #1 rst_n = 1'b1;
    step();
    check_reset_values("post_reset");

    // Basic three-product job, back to back.
    q_r = '{64'(10), 64'(20), 64'(-3)};
    q_i = '{64'(-5), 64'(7), 64'(1)};
    run_job("basic", 0, 0, 0, 1'b0);
    check("basic_const_r", 128'(acc_r_a), 128'(80'd27));
    check("basic_const_i", 128'(acc_i_a), 128'(80'd3));

    // Same job with two idle cycles before each product.
    q_r = '{64'(10), 64'(20), 64'(-3)};
    q_i = '{64'(-5), 64'(7), 64'(1)};
    run_job("gaps", 2, 2, 0, 1'b0);
    check("gaps_const_r", 128'(acc_r_a), 128'(80'd27));

    // Zero-length job goes straight to DONE with zero sums.
    run_job("len0", 0, 0, 2, 1'b0);

    // Consumer stall with start pulses, then start during the handoff.
    q_r = '{64'(-100), 64'(55)};
    q_i = '{64'(9), 64'(-1)};
    run_job("stall", 0, 1, 5, 1'b1);

    // 64-bit lane overflow; the 80-bit instance absorbs it.
    q_r = '{64'h7FFF_FFFF_FFFF_FFFF, 64'(1)};
    q_i = '{64'(0), 64'(0)};
    run_job("ovf", 0, 0, 1, 1'b0);
    check("ovf_const_r64", 128'(acc_r_b), 128'(64'h8000_0000_0000_0000));
    check("ovf_const_flags", 128'({ovf_r_b, ovf_i_b, ovf_r_a}), 128'(3'b100));
    q_r = '{64'(1)};
    q_i = '{64'(2)};
    run_job("ovf_clear", 0, 0, 0, 1'b0);

    // Reset in the middle of a job discards the partial sum.
    start = 1'b1;
    len = 16'd3;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    pr = 64'(77);
    pi = 64'(-77);
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    #2 rst_n = 1'b1;
    step();
    check_reset_values("mid_reset_released");
    q_r = '{64'(4)};
    q_i = '{64'(4)};
    run_job("after_reset", 0, 0, 0, 1'b0);
    check("after_reset_const", 128'({acc_r_a, acc_i_a}), 128'({80'd4, 80'd4}));

    // Randomized jobs with random gaps and stalls.
    for (int j = 0; j < 12; j++) begin
      int n;
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) begin
        q_r.push_back({$urandom, $urandom});
        q_i.push_back({$urandom, $urandom});
      end
      run_job("rand", 0, 2, $urandom_range(3, 0), 1'($urandom_range(1, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/complex_accumulator.md
Name: complex_accumulator

Overview:
- Downstream consumer of the complex_multiplier products (pr, pi), which are treated as signed 64-bit two's-complement values.
- Accumulates a programmed number of complex products into wide real and imaginary sums, giving a complex dot product / MAC result.
- Uses a valid/ready handshake on the input and on the output.
- Flags signed overflow of each accumulator lane.

Parameters:
- PW, 64, product width; matches the complex_multiplier pr/pi width.
- AW, 80, accumulator width; must be >= PW; products are sign-extended to AW.
- LW, 16, width of the length field.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin an accumulation; sampled only in IDLE.
- len  in  LW  number of products to accumulate; sampled together with start.
- in_valid  in  1  pr/pi hold a valid product.
- in_ready  out  1  block accepts a product this cycle.
- pr  in  PW  real product, signed.
- pi  in  PW  imaginary product, signed.
- out_valid  out  1  result is available.
- out_ready  in  1  downstream accepts the result.
- acc_r  out  AW  real sum, signed.
- acc_i  out  AW  imaginary sum, signed.
- ovf_r  out  1  sticky real-lane overflow for the current job.
- ovf_i  out  1  sticky imaginary-lane overflow for the current job.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE.
  - acc_r=0, acc_i=0, count=0.
  - ovf_r=0, ovf_i=0.
  - in_ready=0, out_valid=0, busy=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 clears acc_r, acc_i, ovf_r, ovf_i and loads count=len.
  - If len!=0, next state is ACCUM.
  - If len==0, next state is DONE and the result is zero.
  - start is ignored in every state other than IDLE.
- ACCUM:
  - in_ready=1 combinationally; no other output depends combinationally on inputs.
  - Transfer occurs when in_valid && in_ready.
  - On a transfer: acc_r += sext(pr), acc_i += sext(pi), count -= 1.
  - in_valid gaps are allowed; the accumulators hold through them.
  - The transfer that brings count to 0 moves the FSM to DONE on the same edge.
  - Latency: final sums are visible on acc_r/acc_i and out_valid=1 in the cycle after the last transfer.
- DONE:
  - out_valid=1, in_ready=0.
  - acc_r, acc_i, ovf_r, ovf_i hold stable until out_ready=1.
  - out_valid && out_ready returns the FSM to IDLE; the outputs keep their values until the next accepted start.
  - start asserted in the same cycle as the DONE->IDLE handoff is ignored; it is accepted one cycle later, in IDLE.
- Arithmetic: AW-bit two's-complement addition that wraps on overflow.
  - A lane overflows when both operands have the same sign and the sum's sign differs.
  - An overflow sets that lane's sticky flag, which stays set until the next accepted start.
- Reset mid-operation: immediate return to IDLE with all reset values; any partial sum is discarded.
- len=all-ones (65535 for LW=16) is a legal job length.

Decomposition:
- Package complex_acc_pkg:
  - state enum {IDLE, ACCUM, DONE}.
  - default PW, AW, LW constants.
  - sign-extension helper function.
- Sub-module cplx_acc_lane, instantiated once for the real lane and once for the imaginary lane.
  - Contents: one AW-bit signed accumulator register, clear/add enables, and sticky overflow detection.

Test Plan:
- len=3, products (pr,pi) = (10,-5), (20,7), (-3,1) on consecutive cycles -> out_valid on the cycle after the 3rd transfer; acc_r=27, acc_i=3; ovf_r=0, ovf_i=0.
- Same job with in_valid low for 2 cycles between samples -> same result; count and sums hold during the gaps; in_ready stays 1.
- len=0 with start=1 -> next cycle state=DONE, out_valid=1, acc_r=0, acc_i=0; in_ready never asserts.
- out_ready held low for 5 cycles in DONE -> out_valid and the results stay stable; start pulses during this window are ignored; out_ready=1 -> IDLE on the next edge, busy=0.
- Overflow with AW=64, len=2, pr = 0x7FFF_FFFF_FFFF_FFFF then 1, pi=0 -> acc_r=0x8000_0000_0000_0000, ovf_r=1, ovf_i=0; a following start clears ovf_r.
- rst_n pulsed low mid-ACCUM after 1 of 3 products -> outputs immediately return to reset values; a new job with len=1 and product (4,4) -> result (4,4).
